// File: rtl/ff_d_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ff_d_pipe_pkg
//   Shared definitions for the ff_d_pipe register pipeline.
//   - COLLAPSE mode encodings (bubble-collapsing vs. lockstep advance)
//   - clog2 helper used to size the occupancy counter
// ---------------------------------------------------------------------------
package ff_d_pipe_pkg;

  // Pipeline advance modes selected by the COLLAPSE parameter.
  localparam int COLLAPSE_LOCKSTEP = 0;  // all stages move together
  localparam int COLLAPSE_BUBBLE   = 1;  // each stage has its own ready

  // Mirrors the mode encoding as a type for code that carries it as a signal.
  typedef enum logic {
    MODE_LOCKSTEP = 1'b0,
    MODE_BUBBLE   = 1'b1
  } collapse_mode_e;

  // Ceiling log2, usable in constant expressions (port widths).
  // clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage : ff_d_pipe_pkg

// File: rtl/ff_d_pipe_stage.sv
// ---------------------------------------------------------------------------
// ff_d_pipe_stage
//   One pipeline slot: a valid flag plus a payload register.
//
//   Ports
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset (valid=0, data=RST_DATA)
//     syn_rst   synchronous flush, same effect as reset on the next edge
//     load      slot accepts the value presented on valid_in/data_in
//     valid_in  incoming valid flag (0 loads a bubble)
//     data_in   incoming payload
//     valid     slot holds valid data
//     data      slot payload
// ---------------------------------------------------------------------------
module ff_d_pipe_stage
  import ff_d_pipe_pkg::*;
#(
  parameter int                  DATA_LEN = 1,
  parameter logic [DATA_LEN-1:0] RST_DATA = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                syn_rst,
  input  logic                load,
  input  logic                valid_in,
  input  logic [DATA_LEN-1:0] data_in,
  output logic                valid,
  output logic [DATA_LEN-1:0] data
);

  logic                valid_reg;
  logic [DATA_LEN-1:0] data_reg;

  // The payload register is only enabled when a real item arrives; a bubble
  // moving in updates the valid flag alone, so data never toggles for nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_DATA;
    end else if (syn_rst) begin
      valid_reg <= 1'b0;
      data_reg  <= RST_DATA;
    end else begin
      if (load) begin
        valid_reg <= valid_in;
      end
      if (load && valid_in) begin
        data_reg <= data_in;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule : ff_d_pipe_stage

// File: rtl/ff_d_pipe.sv
// ---------------------------------------------------------------------------
// ff_d_pipe
//   Valid/ready register pipeline of STAGES slots.
//   COLLAPSE=1: each slot loads when it is empty or its successor moves, so
//               bubbles are squeezed out under backpressure.
//   COLLAPSE=0: all slots advance together when the output is empty or
//               being accepted.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     syn_rst    synchronous flush of every slot and the counter
//     in_valid   upstream item present
//     in_ready   pipeline accepts an item this cycle
//     data_in    upstream payload
//     out_valid  last slot holds an item
//     out_ready  downstream accepts the item
//     data_out   last-slot payload
//     count      number of occupied slots
// ---------------------------------------------------------------------------
module ff_d_pipe
  import ff_d_pipe_pkg::*;
#(
  parameter int                  DATA_LEN = 1,
  parameter int                  STAGES   = 2,
  parameter logic [DATA_LEN-1:0] RST_DATA = '0,
  parameter int                  COLLAPSE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         syn_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_LEN-1:0]          data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_LEN-1:0]          data_out,
  output logic [clog2(STAGES+1)-1:0]   count
);

  localparam int            CW        = clog2(STAGES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(STAGES);

  // Elaboration-time parameter sanity.
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("ff_d_pipe: STAGES must be within 1..16");
  end
  if (COLLAPSE != COLLAPSE_BUBBLE && COLLAPSE != COLLAPSE_LOCKSTEP) begin : g_bad_mode
    $error("ff_d_pipe: COLLAPSE must be 0 or 1");
  end

  logic [STAGES-1:0]   stage_valid;
  logic [DATA_LEN-1:0] stage_data [STAGES];

  // ready_chain[i] is the load enable of slot i; the extra top entry is the
  // downstream ready, i.e. the "load" of the consumer behind the last slot.
  logic [STAGES:0]     ready_chain;

  logic                in_xfer;
  logic                out_xfer;
  logic [CW-1:0]       count_reg;

  assign ready_chain[STAGES] = out_ready;

  assign out_valid = stage_valid[STAGES-1];
  assign data_out  = stage_data[STAGES-1];

  // Flush wins over everything: nothing is accepted while syn_rst is high.
  assign in_ready  = ready_chain[0] && !syn_rst;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic                valid_feed;
      logic [DATA_LEN-1:0] data_feed;

      if (gi == 0) begin : g_head
        // Only a completed handshake turns into a valid entry.
        assign valid_feed = in_xfer;
        assign data_feed  = data_in;
      end else begin : g_body
        assign valid_feed = stage_valid[gi-1];
        assign data_feed  = stage_data[gi-1];
      end

      if (COLLAPSE == COLLAPSE_BUBBLE) begin : g_bubble
        // Empty slot always loads; a full one loads only if its contents move on.
        assign ready_chain[gi] = !stage_valid[gi] || ready_chain[gi+1];
      end else begin : g_lockstep
        // Single global advance: the output is free or being consumed.
        assign ready_chain[gi] = !stage_valid[STAGES-1] || ready_chain[STAGES];
      end

      ff_d_pipe_stage #(
        .DATA_LEN (DATA_LEN),
        .RST_DATA (RST_DATA)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .syn_rst  (syn_rst),
        .load     (ready_chain[gi]),
        .valid_in (valid_feed),
        .data_in  (data_feed),
        .valid    (stage_valid[gi]),
        .data     (stage_data[gi])
      );
    end
  endgenerate

  // Occupancy counter tracks handshakes on both ends. The bound checks can
  // never trip with the handshake rules above; they keep the counter
  // saturating should a caller violate valid/ready semantics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (syn_rst) begin
      count_reg <= '0;
    end else if (in_xfer && !out_xfer && count_reg != COUNT_MAX) begin
      count_reg <= count_reg + CW'(1);
    end else if (!in_xfer && out_xfer && count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;

endmodule : ff_d_pipe
